// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx (and the matching uart_tx).
//   uart_state_e          : receiver/transmitter state encoding (3 bits)
//   UART_DATA_BITS        : data bits per frame
//   UART_CLKS_PER_BIT_DEF : default clock cycles per bit
//   maj3()                : 2-of-3 majority helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_CLKS_PER_BIT_DEF = 868;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bus of uart_rx.
//   o_Rx_DV        : one-cycle strobe, o_Rx_Byte holds a new good byte
//   o_Rx_Byte      : last correctly framed byte
//   o_Rx_Frame_Err : one-cycle strobe, stop bit sampled low
//   o_Rx_Active    : frame reception in progress
// Modports: master = uart_rx (drives), slave = consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      o_Rx_DV;
  logic [UART_DATA_BITS-1:0] o_Rx_Byte;
  logic                      o_Rx_Frame_Err;
  logic                      o_Rx_Active;

  modport master (output o_Rx_DV, output o_Rx_Byte, output o_Rx_Frame_Err, output o_Rx_Active);
  modport slave  (input  o_Rx_DV, input  o_Rx_Byte, input  o_Rx_Frame_Err, input  o_Rx_Active);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value. All flops reset to 1 (idle line).
//   i_Clock     : system clock
//   i_Rst_L     : asynchronous active-low reset
//   i_Rx_Serial : raw serial line
//   o_Rx_S      : synchronized line (rx_s)
//   o_Fall      : one-cycle pulse on a 1->0 transition of rx_s
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Rx_Serial,
  output logic o_Rx_S,
  output logic o_Fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= i_Rx_Serial;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign o_Rx_S = sync_q;
  assign o_Fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first. Detects the start edge on the synchronized
// line, samples each bit mid-period, and reports a good byte (o_Rx_DV) or a
// framing error (o_Rx_Frame_Err) with one-cycle strobes.
//   i_Clock     : system clock, rising edge
//   i_Rst_L     : asynchronous active-low reset
//   i_Rx_Serial : asynchronous serial input, idles high
//   rx_bus      : uart_rx_if.master (o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active)
// Parameter CLKS_PER_BIT (>= 4): clock cycles per bit.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around each
// sample point (counts target-1, target, target+1); decision is one cycle later.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic        i_Rx_Serial,
  uart_rx_if.master   rx_bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

`ifdef UART_RX_MAJORITY_EN
  // One extra counter bit: the data/stop decision happens at count CLKS_PER_BIT.
  localparam int             CW     = CNT_W + 1;
  localparam logic [CNT_W:0] RELOAD = (CNT_W + 1)'(1);
`else
  localparam int               CW     = CNT_W;
  localparam logic [CNT_W-1:0] RELOAD = '0;
`endif

  localparam logic [CW-1:0] HALF_T = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .i_Clock     (i_Clock),
    .i_Rst_L     (i_Rst_L),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx_S      (rx_s),
    .o_Fall      (rx_fall)
  );

  uart_state_e               state_q;
  logic [CW-1:0]             cnt_q;
  logic [2:0]                idx_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic [UART_DATA_BITS-1:0] byte_q;
  logic                      dv_q;
  logic                      ferr_q;
  logic                      active_q;

  logic [CW-1:0] target;
  logic          sample_hit;
  logic          sample_bit;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q;
`endif

  always_comb begin
    target = (state_q == START) ? HALF_T : FULL_T;
`ifdef UART_RX_MAJORITY_EN
    sample_hit = (cnt_q == target + CW'(1));
    sample_bit = maj3(vote_q[0], vote_q[1], rx_s);
`else
    sample_hit = (cnt_q == target);
    sample_bit = rx_s;
`endif
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      vote_q   <= '0;
`endif
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;

`ifdef UART_RX_MAJORITY_EN
      if (cnt_q == target - CW'(1)) vote_q[0] <= rx_s;
      if (cnt_q == target)          vote_q[1] <= rx_s;
`endif

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (rx_fall) begin
            state_q  <= START;
            active_q <= 1'b1;
          end
        end

        START: begin
          if (sample_hit) begin
            if (!sample_bit) begin
              state_q <= DATA;
              cnt_q   <= RELOAD;
            end else begin
              // Line went high again before mid start bit: glitch.
              state_q  <= IDLE;
              cnt_q    <= '0;
              active_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (sample_hit) begin
            data_q[idx_q] <= sample_bit;
            cnt_q         <= RELOAD;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (sample_hit) begin
            if (sample_bit) begin
              byte_q <= data_q;
              dv_q   <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
            cnt_q    <= '0;
            active_q <= 1'b0;
            state_q  <= CLEANUP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        CLEANUP: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end

        default: begin
          cnt_q    <= '0;
          idx_q    <= '0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign rx_bus.o_Rx_DV        = dv_q;
  assign rx_bus.o_Rx_Byte      = byte_q;
  assign rx_bus.o_Rx_Frame_Err = ferr_q;
  assign rx_bus.o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT=8. A behavioural transmitter
// drives frames; each frame pushes its expected outcome (byte or framing
// error, start time) to a scoreboard that the output monitor pops.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam int MAJ = 0;
  localparam logic [7:0] GLITCH_EXP = 8'hFB;
`endif
  localparam int EXP_LAT = 2 + 1 + (C - 1) / 2 + 9 * C + MAJ;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic line  = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if rx_if();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .i_Rx_Serial (line),
    .rx_bus      (rx_if)
  );

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    int         t_fall;
  } exp_t;

  exp_t       sb[$];
  int         checks     = 0;
  int         passes     = 0;
  int         dv_cnt     = 0;
  int         ferr_cnt   = 0;
  int         active_cnt = 0;
  logic [7:0] last_good  = 8'h00;
  logic       ev_prev    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin : mon
    exp_t e;
    int   lat;
    if (rst_n) begin
      if (rx_if.o_Rx_Active) active_cnt++;
      if (rx_if.o_Rx_DV || rx_if.o_Rx_Frame_Err) begin
        chk("dv_ferr_exclusive", 32'(rx_if.o_Rx_DV & rx_if.o_Rx_Frame_Err), 0);
        chk("strobe_one_cycle", 32'(ev_prev), 0);
        chk("event_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e   = sb.pop_front();
          lat = cyc - e.t_fall - 1;
          chk("event_kind", 32'(rx_if.o_Rx_Frame_Err), 32'(e.ferr));
          chk("latency", (lat >= EXP_LAT - 2 && lat <= EXP_LAT + 2) ? EXP_LAT : lat, EXP_LAT);
          if (e.ferr) begin
            ferr_cnt++;
            chk("byte_held_on_ferr", 32'(rx_if.o_Rx_Byte), 32'(last_good));
          end else begin
            dv_cnt++;
            chk("rx_byte", 32'(rx_if.o_Rx_Byte), 32'(e.data));
            last_good = e.data;
          end
        end
      end
      ev_prev = rx_if.o_Rx_DV | rx_if.o_Rx_Frame_Err;
    end else begin
      ev_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at the current negedge. glitch_at inverts a
  // single line cycle; rst_at asserts reset at that cycle and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input logic [7:0] exp_b, input logic stop_bit,
                            input int glitch_at, input int rst_at);
    exp_t e;
    logic v;
    int   bitn;
    for (int i = 0; i < 10 * C; i++) begin
      bitn = i / C;
      if (bitn == 0)      v = 1'b0;
      else if (bitn == 9) v = stop_bit;
      else                v = b[bitn-1];
      if (i == glitch_at) v = ~v;
      if (i == 0 && rst_at < 0) begin
        e.ferr   = ~stop_bit;
        e.data   = exp_b;
        e.t_fall = cyc;
        sb.push_back(e);
      end
      if (i == rst_at) begin
        chk("active_before_reset", 32'(rx_if.o_Rx_Active), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_dv", 32'(rx_if.o_Rx_DV), 0);
        chk("mid_reset_ferr", 32'(rx_if.o_Rx_Frame_Err), 0);
        chk("mid_reset_active", 32'(rx_if.o_Rx_Active), 0);
        chk("mid_reset_byte", 32'(rx_if.o_Rx_Byte), 0);
        line = 1'b1;
        @(negedge clk);
        rst_n     = 1'b1;
        last_good = 8'h00;
        return;
      end
      line = v;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 * C && sb.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state
    rst_n = 1'b0;
    line  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dv", 32'(rx_if.o_Rx_DV), 0);
    chk("reset_ferr", 32'(rx_if.o_Rx_Frame_Err), 0);
    chk("reset_active", 32'(rx_if.o_Rx_Active), 0);
    chk("reset_byte", 32'(rx_if.o_Rx_Byte), 0);
    rst_n = 1'b1;
    idle(2 * C);

    // Loopback-style frames
    send_frame(8'hA5, 8'hA5, 1'b1, -1, -1);
    idle(C);
    send_frame(8'h00, 8'h00, 1'b1, -1, -1);
    idle(C);
    send_frame(8'hFF, 8'hFF, 1'b1, -1, -1);
    idle(2 * C);
    drain();
    chk("dv_count_loopback", dv_cnt, 3);
    chk("ferr_count_loopback", ferr_cnt, 0);

    // Short low glitch on the line
    active_cnt = 0;
    line = 1'b0;
    repeat (2) @(negedge clk);
    idle(3 * C);
    chk("glitch_active_cycles", (active_cnt >= 3 && active_cnt <= 6) ? 5 : active_cnt, 5);
    chk("glitch_dv_count", dv_cnt, 3);
    chk("glitch_ferr_count", ferr_cnt, 0);

    // Framing error, then a held-low (break) line
    send_frame(8'h3C, 8'h3C, 1'b0, -1, -1);
    line = 1'b0;
    active_cnt = 0;
    repeat (40) @(negedge clk);
    chk("break_active_cycles", active_cnt, 0);
    chk("ferr_count", ferr_cnt, 1);
    chk("dv_count_after_ferr", dv_cnt, 3);
    chk("byte_after_ferr", 32'(rx_if.o_Rx_Byte), 32'h FF);
    idle(2 * C);

    // Back-to-back frames, no idle between stop and next start
    send_frame(8'h12, 8'h12, 1'b1, -1, -1);
    send_frame(8'h34, 8'h34, 1'b1, -1, -1);
    idle(2 * C);
    drain();
    chk("dv_count_b2b", dv_cnt, 5);
    chk("byte_after_b2b", 32'(rx_if.o_Rx_Byte), 32'h34);

    // Reset in the middle of data bit 4, then a clean frame
    send_frame(8'hC3, 8'hC3, 1'b1, -1, 5 * C + C / 2);
    idle(2 * C);
    chk("dv_count_after_reset", dv_cnt, 5);
    send_frame(8'h5A, 8'h5A, 1'b1, -1, -1);
    idle(2 * C);
    drain();
    chk("dv_count_after_5a", dv_cnt, 6);
    chk("byte_after_5a", 32'(rx_if.o_Rx_Byte), 32'h5A);

    // One-cycle inverted glitch at the middle of data bit 2 of 0xFF
    send_frame(8'hFF, GLITCH_EXP, 1'b1, 3 * C + C / 2, -1);
    idle(2 * C);
    drain();
    chk("dv_count_final", dv_cnt, 7);
    chk("ferr_count_final", ferr_cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
